// File: rtl/mem_wait_bridge_pkg.sv
// Shared definitions for the memory wait-state bridge.
// Latency: none (constants, types and combinational helpers only).
// Backpressure: not applicable.
//
// Contents: memory function codes (M_XRD/M_XWR), access type codes (MT_*),
// the bridge FSM state encoding, a counter-width helper and the access
// alignment check used when MEM_WAIT_BRIDGE_ALIGN_CHECK_EN is defined.
package mem_bridge_pkg;

    // Memory function codes.
    localparam logic M_XRD = 1'b0;
    localparam logic M_XWR = 1'b1;

    // Memory access type codes.
    localparam logic [2:0] MT_B  = 3'd1;
    localparam logic [2:0] MT_H  = 3'd2;
    localparam logic [2:0] MT_W  = 3'd3;
    localparam logic [2:0] MT_BU = 3'd5;
    localparam logic [2:0] MT_HU = 3'd6;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        ISSUE,
        RDWAIT,
        RESP
    } state_t;

    // Counter must hold the larger of the two programmable delays, and is
    // never narrower than 8 bits.
    function automatic int cnt_width(input int lat, input int tmo);
        int m;
        int w;
        m = (lat > tmo) ? lat : tmo;
        w = $clog2(m + 1);
        return (w < 8) ? 8 : w;
    endfunction

    // Halfword accesses need addr[0]==0, word accesses need addr[1:0]==0.
    // Byte accesses are always aligned.
    function automatic logic misaligned(input logic [2:0] typ, input logic [1:0] lo);
        logic bad;
        bad = 1'b0;
        if ((typ == MT_H) || (typ == MT_HU)) begin
            bad = lo[0];
        end else if (typ == MT_W) begin
            bad = (lo != 2'b00);
        end
        return bad;
    endfunction

endpackage

// File: rtl/mem_wait_bridge_if.sv
// Request/response bundle of a single-outstanding memory port.
// Latency: none (wiring only).
// Backpressure: req_valid/req_ready handshake; responses cannot be stalled.
//
// master: drives the request, receives req_ready and the response.
// slave : receives the request, drives req_ready and the response.
interface mem_wait_bridge_if #(
    parameter int AW = 32,
    parameter int DW = 32
) ();
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_data;
    logic          req_fcn;
    logic [2:0]    req_typ;
    logic          resp_valid;
    logic [DW-1:0] resp_data;

    modport master (
        output req_valid, req_addr, req_data, req_fcn, req_typ,
        input  req_ready, resp_valid, resp_data
    );

    modport slave (
        input  req_valid, req_addr, req_data, req_fcn, req_typ,
        output req_ready, resp_valid, resp_data
    );
endinterface

// File: rtl/mem_wait_bridge.sv
// Inserts LATENCY wait states between a core memory port and the memory model.
// Latency: accept to up.resp_valid = LATENCY+2 cycles with a zero-wait memory.
// Backpressure: one request outstanding; up.req_ready only in IDLE, dn request held until dn.req_ready.
//
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   up       : core side (slave modport): request in, ready/response out
//   dn       : memory side (master modport): request out, ready/response in
//   err      : sticky error (response timeout, or misaligned access); cleared by rst only
// Build option: define MEM_WAIT_BRIDGE_ALIGN_CHECK_EN to reject misaligned
// halfword/word accesses without forwarding them to memory.
module mem_wait_bridge
    import mem_bridge_pkg::*;
#(
    parameter int LATENCY = 2,
    parameter int TIMEOUT = 255,
    parameter int AW      = 32,
    parameter int DW      = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    mem_wait_bridge_if.slave     up,
    mem_wait_bridge_if.master    dn,
    output logic                 err
);

    localparam int CW = cnt_width(LATENCY, TIMEOUT);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] data_q, data_d;
    logic          fcn_q, fcn_d;
    logic [2:0]    typ_q, typ_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          mis_q, mis_d;
    logic          err_q, err_d;
    logic          mis_w;

`ifdef MEM_WAIT_BRIDGE_ALIGN_CHECK_EN
    assign mis_w = misaligned(up.req_typ, up.req_addr[1:0]);
`else
    assign mis_w = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            fcn_q   <= 1'b0;
            typ_q   <= 3'd0;
            rdata_q <= '0;
            mis_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            fcn_q   <= fcn_d;
            typ_q   <= typ_d;
            rdata_q <= rdata_d;
            mis_q   <= mis_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        fcn_d   = fcn_q;
        typ_d   = typ_q;
        rdata_d = rdata_q;
        mis_d   = mis_q;
        err_d   = err_q;

        unique case (state_q)
            IDLE: begin
                if (up.req_valid) begin
                    addr_d  = up.req_addr;
                    data_d  = up.req_data;
                    fcn_d   = up.req_fcn;
                    typ_d   = up.req_typ;
                    cnt_d   = CW'(LATENCY);
                    rdata_d = '0;
                    mis_d   = mis_w;
                    if (LATENCY > 0) begin
                        state_d = WAIT;
                    end else if (mis_w) begin
                        // Zero wait states: a rejected access completes at once.
                        state_d = RESP;
                        err_d   = 1'b1;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end

            WAIT: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q <= CW'(1)) begin
                    if (mis_q) begin
                        state_d = RESP;
                        err_d   = 1'b1;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end

            ISSUE: begin
                if (dn.req_ready) begin
                    if (dn.resp_valid) begin
                        rdata_d = dn.resp_data;
                        state_d = RESP;
                    end else begin
                        cnt_d   = CW'(TIMEOUT);
                        state_d = RDWAIT;
                    end
                end
            end

            RDWAIT: begin
                // A response in the final counted cycle still beats the timeout.
                if (dn.resp_valid) begin
                    rdata_d = dn.resp_data;
                    state_d = RESP;
                end else if (cnt_q <= CW'(1)) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end

            RESP: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // All outputs are decoded from registered state only.
    assign up.req_ready  = (state_q == IDLE);
    assign up.resp_valid = (state_q == RESP);
    assign up.resp_data  = ((state_q == RESP) && (fcn_q == M_XRD)) ? rdata_q : '0;

    assign dn.req_valid  = (state_q == ISSUE);
    assign dn.req_addr   = addr_q;
    assign dn.req_data   = data_q;
    assign dn.req_fcn    = fcn_q;
    assign dn.req_typ    = typ_q;

    assign err = err_q;

endmodule

// File: tb/tb_mem_wait_bridge.sv
// Directed bench: dut_a (LATENCY=2, TIMEOUT=4) and dut_b (LATENCY=0).
// Inputs are driven and outputs checked 2 time units after each rising edge.
module tb_mem_wait_bridge;
    import mem_bridge_pkg::*;

    logic clk;
    logic rst;
    int   nerr;
    int   nchk;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mem_wait_bridge_if #(.AW(32), .DW(32)) aup ();
    mem_wait_bridge_if #(.AW(32), .DW(32)) adn ();
    mem_wait_bridge_if #(.AW(32), .DW(32)) bup ();
    mem_wait_bridge_if #(.AW(32), .DW(32)) bdn ();

    logic a_err;
    logic b_err;

    mem_wait_bridge #(.LATENCY(2), .TIMEOUT(4), .AW(32), .DW(32)) dut_a (
        .clk (clk),
        .rst (rst),
        .up  (aup),
        .dn  (adn),
        .err (a_err)
    );

    mem_wait_bridge #(.LATENCY(0), .TIMEOUT(255), .AW(32), .DW(32)) dut_b (
        .clk (clk),
        .rst (rst),
        .up  (bup),
        .dn  (bdn),
        .err (b_err)
    );

    // Memory model for dut_a: controllable ready, same-cycle response enable,
    // and a forced response strobe independent of any handshake.
    logic        a_rdy;
    logic        a_en;
    logic        a_late;
    logic [31:0] a_mdata;

    assign adn.req_ready  = a_rdy;
    assign adn.resp_valid = (adn.req_valid & a_rdy & a_en) | a_late;
    assign adn.resp_data  = a_mdata;

    // Memory model for dut_b: always ready, responds in the same cycle.
    logic [31:0] memb [16];

    assign bdn.req_ready  = 1'b1;
    assign bdn.resp_valid = bdn.req_valid;
    assign bdn.resp_data  = memb[bdn.req_addr[5:2]];

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) memb[i] <= 32'hCAFE0000;
        end else if (bdn.req_valid && bdn.req_fcn) begin
            memb[bdn.req_addr[5:2]] <= bdn.req_data;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
        nchk++;
        assert (obs === req) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, req);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic a_drive(input logic v, input logic [31:0] addr, input logic [31:0] data,
                           input logic fcn, input logic [2:0] typ);
        aup.req_valid = v;
        aup.req_addr  = addr;
        aup.req_data  = data;
        aup.req_fcn   = fcn;
        aup.req_typ   = typ;
    endtask

    task automatic b_drive(input logic v, input logic [31:0] addr, input logic [31:0] data,
                           input logic fcn, input logic [2:0] typ);
        bup.req_valid = v;
        bup.req_addr  = addr;
        bup.req_data  = data;
        bup.req_fcn   = fcn;
        bup.req_typ   = typ;
    endtask

    initial begin
        nerr    = 0;
        nchk    = 0;
        rst     = 1'b1;
        a_rdy   = 1'b1;
        a_en    = 1'b1;
        a_late  = 1'b0;
        a_mdata = 32'hDEADBEEF;
        a_drive(1'b0, 32'h0, 32'h0, M_XRD, MT_W);
        b_drive(1'b0, 32'h0, 32'h0, M_XRD, MT_W);
        #3;

        // Reset values.
        chk("rst_a_ready",     32'(aup.req_ready),  32'd1);
        chk("rst_a_respvalid", 32'(aup.resp_valid), 32'd0);
        chk("rst_a_respdata",  aup.resp_data,       32'd0);
        chk("rst_a_dnvalid",   32'(adn.req_valid),  32'd0);
        chk("rst_a_dnaddr",    adn.req_addr,        32'd0);
        chk("rst_a_dndata",    adn.req_data,        32'd0);
        chk("rst_a_dnfcntyp",  32'({adn.req_fcn, adn.req_typ}), 32'd0);
        chk("rst_a_err",       32'(a_err),          32'd0);
        chk("rst_b_ready",     32'(bup.req_ready),  32'd1);
        @(negedge clk);
        rst = 1'b0;
        cyc();

        // Read 0x100 through a 2-wait-state bridge, combinational memory.
        a_drive(1'b1, 32'h100, 32'h0, M_XRD, MT_W);
        chk("t1_ready_c0", 32'(aup.req_ready), 32'd1);
        cyc();
        a_drive(1'b0, 32'h0, 32'h0, M_XRD, MT_W);
        chk("t1_ready_c1",   32'(aup.req_ready), 32'd0);
        chk("t1_dnvalid_c1", 32'(adn.req_valid), 32'd0);
        cyc();
        chk("t1_ready_c2",   32'(aup.req_ready), 32'd0);
        chk("t1_dnvalid_c2", 32'(adn.req_valid), 32'd0);
        cyc();
        chk("t1_ready_c3",   32'(aup.req_ready),  32'd0);
        chk("t1_dnvalid_c3", 32'(adn.req_valid),  32'd1);
        chk("t1_dnaddr_c3",  adn.req_addr,        32'h100);
        chk("t1_resp_c3",    32'(aup.resp_valid), 32'd0);
        cyc();
        chk("t1_resp_c4",    32'(aup.resp_valid), 32'd1);
        chk("t1_data_c4",    aup.resp_data,       32'hDEADBEEF);
        chk("t1_ready_c4",   32'(aup.req_ready),  32'd0);
        cyc();
        chk("t1_resp_c5",    32'(aup.resp_valid), 32'd0);
        chk("t1_ready_c5",   32'(aup.req_ready),  32'd1);
        chk("t1_data_c5",    aup.resp_data,       32'd0);

        // dut_b: word read at 0x102.
        b_drive(1'b1, 32'h102, 32'h0, M_XRD, MT_W);
        cyc();
        b_drive(1'b0, 32'h0, 32'h0, M_XRD, MT_W);
`ifdef MEM_WAIT_BRIDGE_ALIGN_CHECK_EN
        chk("mis_dnvalid_c1", 32'(bdn.req_valid),  32'd0);
        chk("mis_resp_c1",    32'(bup.resp_valid), 32'd1);
        chk("mis_data_c1",    bup.resp_data,       32'd0);
        chk("mis_err_c1",     32'(b_err),          32'd1);
        cyc();
        chk("mis_dnvalid_c2", 32'(bdn.req_valid),  32'd0);
        chk("mis_err_c2",     32'(b_err),          32'd1);
`else
        chk("mis_dnvalid_c1", 32'(bdn.req_valid),  32'd1);
        chk("mis_dnaddr_c1",  bdn.req_addr,        32'h102);
        chk("mis_resp_c1",    32'(bup.resp_valid), 32'd0);
        cyc();
        chk("mis_resp_c2",    32'(bup.resp_valid), 32'd1);
        chk("mis_data_c2",    bup.resp_data,       32'hCAFE0000);
        chk("mis_err_c2",     32'(b_err),          32'd0);
`endif
        cyc();

        // dut_b: write 0x200 then read it back, zero wait states.
        b_drive(1'b1, 32'h200, 32'h12345678, M_XWR, MT_W);
        chk("t2_ready_c0", 32'(bup.req_ready), 32'd1);
        cyc();
        b_drive(1'b0, 32'h0, 32'h0, M_XRD, MT_W);
        chk("t2_dnvalid_c1", 32'(bdn.req_valid), 32'd1);
        chk("t2_dnfcn_c1",   32'(bdn.req_fcn),   32'd1);
        chk("t2_dndata_c1",  bdn.req_data,       32'h12345678);
        cyc();
        chk("t2_wresp_c2",   32'(bup.resp_valid), 32'd1);
        chk("t2_wdata_c2",   bup.resp_data,       32'd0);
        cyc();
        chk("t2_ready_c3",   32'(bup.req_ready),  32'd1);
        b_drive(1'b1, 32'h200, 32'h0, M_XRD, MT_W);
        cyc();
        b_drive(1'b0, 32'h0, 32'h0, M_XRD, MT_W);
        chk("t2_rresp_c4",   32'(bup.resp_valid), 32'd0);
        cyc();
        chk("t2_rresp_c5",   32'(bup.resp_valid), 32'd1);
        chk("t2_rdata_c5",   bup.resp_data,       32'h12345678);
        cyc();

        // dut_a: downstream not ready for 5 ISSUE cycles.
        a_rdy = 1'b0;
        a_drive(1'b1, 32'h44, 32'hA5A5A5A5, M_XWR, MT_B);
        cyc();
        a_drive(1'b0, 32'h0, 32'h0, M_XRD, MT_W);
        cyc();
        cyc();
        for (int i = 0; i < 5; i++) begin
            if (i > 0) cyc();
            chk("t3_dnvalid", 32'(adn.req_valid),  32'd1);
            chk("t3_dnaddr",  adn.req_addr,        32'h44);
            chk("t3_dndata",  adn.req_data,        32'hA5A5A5A5);
            chk("t3_dnfcn",   32'(adn.req_fcn),    32'd1);
            chk("t3_dntyp",   32'(adn.req_typ),    32'(MT_B));
            chk("t3_resp",    32'(aup.resp_valid), 32'd0);
        end
        cyc();
        a_rdy = 1'b1;
        chk("t3_dnvalid_c8", 32'(adn.req_valid), 32'd1);
        cyc();
        chk("t3_resp_c9",    32'(aup.resp_valid), 32'd1);
        chk("t3_data_c9",    aup.resp_data,       32'd0);
        cyc();
        chk("t3_ready_c10",  32'(aup.req_ready),  32'd1);

        // dut_a: memory never responds, TIMEOUT=4.
        a_en = 1'b0;
        a_drive(1'b1, 32'h300, 32'h0, M_XRD, MT_W);
        cyc();
        a_drive(1'b0, 32'h0, 32'h0, M_XRD, MT_W);
        cyc();
        cyc();
        chk("t4_dnvalid_c3", 32'(adn.req_valid), 32'd1);
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("t4_resp_rdwait", 32'(aup.resp_valid), 32'd0);
            chk("t4_err_rdwait",  32'(a_err),          32'd0);
            chk("t4_dnvalid_rdwait", 32'(adn.req_valid), 32'd0);
        end
        cyc();
        chk("t4_resp_c8",  32'(aup.resp_valid), 32'd1);
        chk("t4_data_c8",  aup.resp_data,       32'd0);
        chk("t4_err_c8",   32'(a_err),          32'd1);
        cyc();
        chk("t4_err_c9",   32'(a_err),          32'd1);
        chk("t4_ready_c9", 32'(aup.req_ready),  32'd1);

        // dut_a: response arrives in the expiry cycle and wins.
        a_drive(1'b1, 32'h304, 32'h0, M_XRD, MT_W);
        cyc();
        a_drive(1'b0, 32'h0, 32'h0, M_XRD, MT_W);
        for (int i = 0; i < 6; i++) cyc();
        a_late = 1'b1;
        chk("t5_resp_c7", 32'(aup.resp_valid), 32'd0);
        cyc();
        a_late = 1'b0;
        chk("t5_resp_c8", 32'(aup.resp_valid), 32'd1);
        chk("t5_data_c8", aup.resp_data,       32'hDEADBEEF);
        chk("t5_err_c8",  32'(a_err),          32'd1);
        cyc();

        // dut_a: stray response while IDLE is ignored.
        a_late = 1'b1;
        cyc();
        a_late = 1'b0;
        chk("t6_resp", 32'(aup.resp_valid), 32'd0);
        chk("t6_ready", 32'(aup.req_ready), 32'd1);

        // dut_a: reset asserted in WAIT.
        a_en = 1'b1;
        a_drive(1'b1, 32'h400, 32'h0, M_XRD, MT_W);
        cyc();
        a_drive(1'b0, 32'h0, 32'h0, M_XRD, MT_W);
        chk("t7_ready_wait", 32'(aup.req_ready), 32'd0);
        #1;
        rst = 1'b1;
        #1;
        chk("t7_rst_ready",  32'(aup.req_ready),  32'd1);
        chk("t7_rst_resp",   32'(aup.resp_valid), 32'd0);
        chk("t7_rst_dnval",  32'(adn.req_valid),  32'd0);
        chk("t7_rst_dnaddr", adn.req_addr,        32'd0);
        chk("t7_rst_err",    32'(a_err),          32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cyc();
            chk("t7_no_resp",   32'(aup.resp_valid), 32'd0);
            chk("t7_no_dnval",  32'(adn.req_valid),  32'd0);
        end

        // dut_a: normal read after the aborted transaction.
        a_mdata = 32'h0BADF00D;
        a_drive(1'b1, 32'h500, 32'h0, M_XRD, MT_W);
        cyc();
        a_drive(1'b0, 32'h0, 32'h0, M_XRD, MT_W);
        cyc();
        cyc();
        chk("t7_dnaddr_c3", adn.req_addr, 32'h500);
        cyc();
        chk("t7_resp_c4", 32'(aup.resp_valid), 32'd1);
        chk("t7_data_c4", aup.resp_data,       32'h0BADF00D);
        chk("t7_err_c4",  32'(a_err),          32'd0);
        cyc();

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/mem_wait_bridge.md
Name: mem_wait_bridge

Overview:
- Inserted between a core memory port (imem or dmem) and the single-cycle `memory` model.
- Adds a programmable number of wait states to each access, which exercises the core's ready/valid stall paths.
- Holds one outstanding request and sequences the downstream handshake.
- Returns exactly one response per accepted request.

Parameters:
- LATENCY, 2: wait cycles inserted between upstream accept and downstream issue; 0 is legal.
- TIMEOUT, 255: maximum cycles spent waiting for a downstream response before an error completion.
- AW, 32: address width.
- DW, 32: data width.

Ports:
- clk  input  1  clock.
- rst  input  1  reset; asynchronous, active-high.
- up_req_valid  input  1  core request valid.
- up_req_ready  output  1  bridge can accept a request.
- up_req_addr  input  AW  request address.
- up_req_data  input  DW  write data.
- up_req_fcn  input  1  access function: 0 = read, 1 = write.
- up_req_typ  input  3  access type: MT_B=1, MT_H=2, MT_W=3, MT_BU=5, MT_HU=6.
- up_resp_valid  output  1  response valid (one-cycle pulse).
- up_resp_data  output  DW  read data returned to the core.
- dn_req_valid  output  1  request valid to memory.
- dn_req_ready  input  1  memory accepts the request.
- dn_req_addr, dn_req_data, dn_req_fcn, dn_req_typ  output  AW/DW/1/3  latched request fields.
- dn_resp_valid  input  1  memory response valid.
- dn_resp_data  input  DW  memory read data.
- err  output  1  sticky error flag; cleared only by rst.

Behaviour:
- Reset (async, active-high): state=IDLE, counter=0, all latched fields=0. Output values during reset:
  - up_req_ready=1
  - up_resp_valid=0, up_resp_data=0
  - dn_req_valid=0, all dn_req_* fields=0
  - err=0
- Reset asserted mid-operation aborts the transaction; no response is produced.
- IDLE:
  - up_req_ready=1.
  - On up_req_valid & up_req_ready, latch addr/data/fcn/typ and load counter=LATENCY.
  - Next state is WAIT if LATENCY>0, otherwise ISSUE.
- WAIT:
  - up_req_ready=0; decrement counter each cycle.
  - When counter reaches 1, next state is ISSUE.
- ISSUE:
  - dn_req_valid=1 with the latched fields, held stable until dn_req_ready.
  - Handshake with dn_resp_valid in the same cycle: capture dn_resp_data, go to RESP.
  - Handshake without dn_resp_valid: load counter=TIMEOUT, go to RDWAIT.
- RDWAIT:
  - On dn_resp_valid, capture data and go to RESP.
  - If counter expires first: set err, force captured data=0, go to RESP.
  - dn_resp_valid arriving in the expiry cycle wins over the timeout.
- RESP:
  - up_resp_valid=1 for exactly one cycle.
  - up_resp_data = captured data for reads, 0 for writes.
  - Next state is IDLE.
- Latency:
  - Upstream accept (cycle 0) to up_resp_valid = LATENCY+2 cycles with a zero-wait memory.
  - up_req_ready returns to 1 in the cycle after RESP.
- No pipelining: back-to-back requests are spaced by at least LATENCY+3 cycles.
- dn_resp_valid is ignored in IDLE, WAIT and RESP; no spurious upstream response is generated.
- Counters are 8-bit minimum and sized to cover max(LATENCY, TIMEOUT).

Optional Feature:
- Macro MEM_WAIT_BRIDGE_ALIGN_CHECK_EN.
- Defined:
  - In IDLE, an accepted request with typ H/HU and addr[0]!=0 is misaligned.
  - An accepted request with typ W and addr[1:0]!=0 is misaligned.
  - A misaligned request is never issued downstream: state goes directly to RESP after the LATENCY wait, err is set, and up_resp_data=0.
- Undefined: no alignment check; all requests are forwarded. err is set only by timeout.

Decomposition:
- Package mem_bridge_pkg holds:
  - fcn constants M_XRD/M_XWR
  - typ constants MT_*
  - state enum {IDLE, WAIT, ISSUE, RDWAIT, RESP}
- The alignment check is a small combinational function inside the package.
- No sub-module; the single FSM plus counter is kept in one module.

Test Plan:
- LATENCY=2, read addr 0x100 with memory returning 0xDEADBEEF combinationally → up_resp_valid in cycle 4 after accept with data 0xDEADBEEF; up_req_ready=0 in cycles 1-4.
- LATENCY=0, write addr 0x200 data 0x12345678, then read the same address → write response data=0 at cycle 2; read returns 0x12345678.
- dn_req_ready held low for 5 cycles in ISSUE → dn_req_valid and all dn_req_* fields stay stable; response arrives 5 cycles later than nominal.
- Memory never asserts dn_resp_valid, TIMEOUT=4 → err=1, up_resp_valid with data 0 after 4 RDWAIT cycles; err stays 1 until rst.
- rst asserted while in WAIT → outputs go to reset values asynchronously; no up_resp_valid after release; next request is processed normally.
- With MEM_WAIT_BRIDGE_ALIGN_CHECK_EN defined, word read at 0x102 → dn_req_valid never asserts; err=1; up_resp_data=0.
